// File: rtl/pll_audio_frac_ce.sv
// Fractional MCLK/BCLK/LRCLK clock-enable generator with two selectable rate families.
// Rate changes are deferred to a frame boundary; locked drops until a full new-rate frame completes.
module pll_audio_frac_ce #(
  parameter int NUM0           = 768,
  parameter int DEN0           = 3125,
  parameter int NUM1           = 3528,
  parameter int DEN1           = 15625,
  parameter int ACC_W          = 16,
  parameter int MCLK_PER_BCLK  = 4,
  parameter int BCLK_PER_FRAME = 64
) (
  input  logic i_refclk,
  input  logic i_rst,
  input  logic i_rate_sel,
  output logic o_mclk_ce,
  output logic o_bclk_ce,
  output logic o_lrclk,
  output logic o_sample_stb,
  output logic o_rate_active,
  output logic o_locked
);
  localparam int MW = (MCLK_PER_BCLK > 1) ? $clog2(MCLK_PER_BCLK) : 1;
  localparam int BW = $clog2(BCLK_PER_FRAME);
  localparam logic [ACC_W-1:0] N0 = ACC_W'(NUM0);
  localparam logic [ACC_W-1:0] D0 = ACC_W'(DEN0);
  localparam logic [ACC_W-1:0] N1 = ACC_W'(NUM1);
  localparam logic [ACC_W-1:0] D1 = ACC_W'(DEN1);
  localparam logic [MW-1:0] MLAST = MW'(MCLK_PER_BCLK - 1);
  localparam logic [BW-1:0] BLAST = BW'(BCLK_PER_FRAME - 1);
  localparam logic [BW-1:0] BPRE  = BW'(BCLK_PER_FRAME / 2 - 1);

  typedef enum logic [1:0] {S_RUN, S_PEND, S_SETTLE} state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [MW-1:0]    r_mcnt;
  logic [BW-1:0]    r_bcnt;
  logic             r_mclk_ce, r_bclk_ce, r_lrclk, r_stb;
  logic             r_rate_active, r_locked, r_sel;

  logic [ACC_W-1:0] w_num, w_den, w_sum;
  logic             w_carry, w_bclk, w_stb, w_half, w_mism, w_switch;

  // acc + NUM < 2*DEN <= 2^ACC_W, so the sum never overflows ACC_W bits
  assign w_num    = r_rate_active ? N1 : N0;
  assign w_den    = r_rate_active ? D1 : D0;
  assign w_sum    = r_acc + w_num;
  assign w_carry  = (w_sum >= w_den);
  assign w_bclk   = w_carry && (r_mcnt == MLAST);
  assign w_stb    = w_bclk && (r_bcnt == BLAST);
  assign w_half   = w_bclk && (r_bcnt == BPRE);
  assign w_mism   = (r_sel != r_rate_active);
  assign w_switch = (r_state == S_PEND) && w_mism && w_stb;

  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_acc     <= '0;
      r_mcnt    <= '0;
      r_bcnt    <= '0;
      r_mclk_ce <= 1'b0;
      r_bclk_ce <= 1'b0;
      r_lrclk   <= 1'b0;
      r_stb     <= 1'b0;
    end else begin
      r_mclk_ce <= w_carry;
      r_bclk_ce <= w_bclk;
      r_stb     <= w_stb;
      if (w_switch)     r_acc <= '0;
      else if (w_carry) r_acc <= w_sum - w_den;
      else              r_acc <= w_sum;
      if (w_carry) r_mcnt <= (r_mcnt == MLAST) ? '0 : r_mcnt + MW'(1);
      if (w_bclk)  r_bcnt <= (r_bcnt == BLAST) ? '0 : r_bcnt + BW'(1);
      if (w_stb)       r_lrclk <= 1'b0;
      else if (w_half) r_lrclk <= 1'b1;
    end
  end

  // The switching strobe is still reported with the old locked value; the drop lands one cycle later.
  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_state       <= S_SETTLE;
      r_locked      <= 1'b0;
      r_rate_active <= i_rate_sel;
      r_sel         <= i_rate_sel;
    end else begin
      r_sel <= i_rate_sel;
      case (r_state)
        S_RUN: if (w_mism) r_state <= S_PEND;
        S_PEND: begin
          // a revert out of an unlocked PEND must still wait out a full frame
          if (!w_mism)    r_state <= r_locked ? S_RUN : S_SETTLE;
          else if (w_stb) begin
            r_rate_active <= r_sel;
            r_state       <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (w_mism) begin
            r_state  <= S_PEND;
            r_locked <= 1'b0;
          end else if (w_stb) begin
            r_locked <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            r_locked <= 1'b0;
          end
        end
        default: r_state <= S_SETTLE;
      endcase
    end
  end

  assign o_mclk_ce     = r_mclk_ce;
  assign o_bclk_ce     = r_bclk_ce;
  assign o_lrclk       = r_lrclk;
  assign o_sample_stb  = r_stb;
  assign o_rate_active = r_rate_active;
  assign o_locked      = r_locked;
endmodule

// File: tb/tb_pll_audio_frac_ce.sv
// Scoreboard bench: a pulse-schedule model (k-th MCLK pulse at anchor + ceil(k*DEN/NUM)) feeds
// an expectation queue; a negedge monitor compares every cycle against it.
module tb_pll_audio_frac_ce;
  localparam int N0 = 768, D0 = 3125, N1 = 3528, D1 = 15625;
  localparam int MPB = 4, BPF = 64, FR = MPB * BPF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic mclk_ce, bclk_ce, lrclk, sample_stb, rate_active, locked;

  pll_audio_frac_ce dut (
    .i_refclk(clk), .i_rst(rst), .i_rate_sel(sel),
    .o_mclk_ce(mclk_ce), .o_bclk_ce(bclk_ce), .o_lrclk(lrclk),
    .o_sample_stb(sample_stb), .o_rate_active(rate_active), .o_locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic bc; logic st; } ev_t;
  ev_t q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nm, got, exp, $time / 10);
    end
  endtask

  // Reference model: pulse times from the anchor (last reset edge or last rate switch)
  int     cyc = 0;
  int     k = 0;
  int     m_p;
  longint anchor = 0, m_num, m_den, nstb = 0;
  logic   e_ra = 1'b0, e_lk = 1'b0, e_lr = 1'b0;
  bit     drop = 1'b0, started = 1'b0;
  logic   m_bc, m_st;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      started = 1'b1;
      anchor = cyc; k = 0;
      e_ra = sel; e_lk = 1'b0; e_lr = 1'b0; drop = 1'b0;
    end else begin
      if (drop) begin e_lk = 1'b0; drop = 1'b0; end
      m_num = e_ra ? N1 : N0;
      m_den = e_ra ? D1 : D0;
      if (longint'(cyc) == anchor + ((longint'(k + 1) * m_den + m_num - 1) / m_num)) begin
        k++;
        m_p  = ((k - 1) % FR) + 1;
        m_bc = (m_p % MPB) == 0;
        m_st = (m_p == FR);
        e_lr = (m_p >= FR / 2) && (m_p < FR);
        q.push_back('{cyc, m_bc, m_st});
        if (m_st) begin
          if (sel != e_ra) begin
            e_ra = sel; drop = 1'b1; anchor = cyc; k = 0;
          end else begin
            e_lk = 1'b1;
          end
        end
      end
    end
    m_num = e_ra ? N1 : N0;
    m_den = e_ra ? D1 : D0;
    nstb = anchor + ((longint'((k / FR + 1) * FR) * m_den + m_num - 1) / m_num);
  end

  // Monitor
  initial forever begin
    bit due;
    @(negedge clk);
    if (started) begin
      due = (q.size() > 0) && (q[0].cyc == cyc);
      chk("pulse", {mclk_ce, bclk_ce, sample_stb}, due ? {1'b1, q[0].bc, q[0].st} : 3'b000);
      chk("levels", {lrclk, rate_active, locked}, {e_lr, e_ra, e_lk});
      if (due) void'(q.pop_front());
    end
  end

  // Rate changes are kept clear of the final few cycles before a frame boundary
  task automatic set_sel(input logic v);
    for (int g = 0; g < 20000 && (nstb - cyc) <= 8; g++) @(negedge clk);
    sel = v;
  endtask

  task automatic wait_stb();
    int n = 0;
    do begin @(negedge clk); n++; end while (!sample_stb && n < 20000);
    chk("stb_timeout", sample_stb, 1'b1);
  endtask

  int cnt, first, cntb;
  bit seen;
  logic prev_lr;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset", {mclk_ce, bclk_ce, lrclk, sample_stb, locked, rate_active}, 6'b000000);
    rst = 1'b0;

    // rate 0 from reset
    cnt = 0; first = 0;
    for (int t = 1; t <= D0; t++) begin
      @(negedge clk);
      if (mclk_ce) begin cnt++; if (first == 0) first = t; end
    end
    chk("first_mclk_edge", first, 5);
    chk("rate0_count", cnt, N0);

    // steady rate 0: LR halves and strobe polarity
    cntb = 0; seen = 1'b0; prev_lr = lrclk;
    repeat (10000) begin
      @(negedge clk);
      if (bclk_ce) cntb++;
      if (sample_stb) chk("stb_lr", lrclk, 1'b0);
      if (lrclk != prev_lr) begin
        if (seen) chk("lr_half", cntb, BPF / 2);
        cntb = 0; seen = 1'b1;
      end
      prev_lr = lrclk;
    end

    // 0 -> 1 mid-frame
    wait_stb();
    repeat (300) @(negedge clk);
    set_sel(1'b1);
    wait_stb();
    chk("switch_ra", rate_active, 1'b1);
    chk("switch_lk_hold", locked, 1'b1);
    cnt = 0;
    for (int t = 1; t <= D1; t++) begin
      @(negedge clk);
      if (t == 1) chk("lock_drop", locked, 1'b0);
      if (mclk_ce) cnt++;
    end
    chk("rate1_count", cnt, N1);

    // glitch inside one frame: no switch
    wait_stb();
    repeat (200) @(negedge clk);
    set_sel(1'b0);
    repeat (3) @(negedge clk);
    set_sel(1'b1);
    wait_stb();
    chk("glitch_ra", rate_active, 1'b1);
    chk("glitch_lk", locked, 1'b1);

    // toggle during SETTLE
    set_sel(1'b0);
    wait_stb();
    chk("switch0_ra", rate_active, 1'b0);
    repeat (50) @(negedge clk);
    set_sel(1'b1);
    wait_stb();
    chk("reswitch", {rate_active, locked}, 2'b10);
    wait_stb();
    chk("relock", locked, 1'b1);

    // random rate requests
    repeat (20) begin
      repeat ($urandom_range(50, 1200)) @(negedge clk);
      set_sel(1'($urandom_range(0, 1)));
    end

    // reset while a switch is pending
    set_sel(~e_ra);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_pend", {mclk_ce, bclk_ce, lrclk, sample_stb, locked, rate_active}, {5'b00000, sel});
    rst = 1'b0;
    first = 0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (mclk_ce && first == 0) first = t;
    end
    chk("first_mclk_after_rst", first, 5);
    repeat (3000) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
